// File: rtl/fp_pkg.sv
// Shared floating-point types, formats and constants for the FPU operation scheduler.
// Format-dependent constants are returned 64 bits wide; callers size-cast to FP_WIDTH.
package fp_pkg;

   typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2, BF16 = 2'd3} fp_format_e;

   typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_FMA = 3'd3,
      OP_DIV = 3'd4
   } fp_op_e;

   typedef enum logic [1:0] {IDLE, FMA_EXEC, DIV_START, DIV_WAIT} sched_state_e;

   function automatic int unsigned fp_width(input fp_format_e fmt);
      case (fmt)
         FP64:    return 64;
         FP16:    return 16;
         BF16:    return 16;
         default: return 32;
      endcase
   endfunction

   function automatic logic [63:0] fp_one(input fp_format_e fmt);
      case (fmt)
         FP64:    return 64'h3FF0_0000_0000_0000;
         FP16:    return 64'h3C00;
         BF16:    return 64'h3F80;
         default: return 64'h3F80_0000;
      endcase
   endfunction

   function automatic logic [63:0] canonical_nan(input fp_format_e fmt);
      case (fmt)
         FP64:    return 64'h7FF8_0000_0000_0000;
         FP16:    return 64'h7E00;
         BF16:    return 64'h7FC0;
         default: return 64'h7FC0_0000;
      endcase
   endfunction

endpackage

// File: rtl/fp_op_sched.sv
// Single-issue scheduler mapping FP ops onto a shared FMA datapath or an iterative divider,
// with a one-entry response register and valid/ready handshakes on both sides.
module fp_op_sched
   import fp_pkg::*;
#(
   parameter fp_format_e  FP_FORMAT = FP32,
   parameter int unsigned TAG_WIDTH = 4,
   localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  fp_op_e               req_op_i,
   input  logic [FP_WIDTH-1:0]  req_a_i,
   input  logic [FP_WIDTH-1:0]  req_b_i,
   input  logic [FP_WIDTH-1:0]  req_c_i,
   input  roundmode_e           req_rnd_i,
   input  logic [TAG_WIDTH-1:0] req_tag_i,
   output logic [FP_WIDTH-1:0]  fma_a_o,
   output logic [FP_WIDTH-1:0]  fma_b_o,
   output logic [FP_WIDTH-1:0]  fma_c_o,
   output logic                 fma_sub_o,
   output roundmode_e           fma_rnd_o,
   input  logic [FP_WIDTH-1:0]  fma_result_i,
   input  status_t              fma_flags_i,
   output logic                 div_start_o,
   output logic [FP_WIDTH-1:0]  div_a_o,
   output logic [FP_WIDTH-1:0]  div_b_o,
   output roundmode_e           div_rnd_o,
   input  logic                 div_done_i,
   input  logic [FP_WIDTH-1:0]  div_result_i,
   input  status_t              div_flags_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [FP_WIDTH-1:0]  rsp_result_o,
   output status_t              rsp_flags_o,
   output logic [TAG_WIDTH-1:0] rsp_tag_o
);

   localparam logic [FP_WIDTH-1:0] FP_ONE = FP_WIDTH'(fp_one(FP_FORMAT));
   localparam logic [FP_WIDTH-1:0] FP_NAN = FP_WIDTH'(canonical_nan(FP_FORMAT));
   localparam status_t NV_ONLY = '{nv: 1'b1, default: 1'b0};

   sched_state_e         state_reg, state_next;
   fp_op_e               op_reg;
   logic [FP_WIDTH-1:0]  a_reg, b_reg, c_reg;
   roundmode_e           rnd_reg;
   logic [TAG_WIDTH-1:0] tag_reg;
   logic                 rsp_valid_reg;
   logic [FP_WIDTH-1:0]  rsp_result_reg, rsp_result_next;
   status_t              rsp_flags_reg, rsp_flags_next;
   logic [TAG_WIDTH-1:0] rsp_tag_reg;
   logic                 accept, rsp_load;

   // Gated by reset so no request can be taken while the block is held in reset.
   assign req_ready_o = reset_i && (state_reg == IDLE) && (!rsp_valid_reg || rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next      = state_reg;
      rsp_load        = 1'b0;
      rsp_result_next = div_result_i;
      rsp_flags_next  = div_flags_i;
      fma_a_o         = '0;
      fma_b_o         = '0;
      fma_c_o         = '0;
      fma_sub_o       = 1'b0;
      fma_rnd_o       = RNE;
      div_start_o     = 1'b0;
      div_a_o         = '0;
      div_b_o         = '0;
      div_rnd_o       = RNE;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = (req_op_i == OP_DIV) ? DIV_START : FMA_EXEC;
         end
         FMA_EXEC: begin
            rsp_load        = 1'b1;
            rsp_result_next = fma_result_i;
            rsp_flags_next  = fma_flags_i;
            state_next      = IDLE;
            fma_rnd_o       = rnd_reg;
            case (op_reg)
               OP_ADD: begin fma_a_o = a_reg; fma_b_o = FP_ONE; fma_c_o = b_reg; end
               OP_SUB: begin fma_a_o = a_reg; fma_b_o = FP_ONE; fma_c_o = b_reg; fma_sub_o = 1'b1; end
               // a*b - (+0) keeps the sign of an exact-zero product except when rounding down
               OP_MUL: begin fma_a_o = a_reg; fma_b_o = b_reg; fma_sub_o = (rnd_reg != RDN); end
               OP_FMA: begin fma_a_o = a_reg; fma_b_o = b_reg; fma_c_o = c_reg; end
               default: begin
                  fma_rnd_o       = RNE;
                  rsp_result_next = FP_NAN;
                  rsp_flags_next  = NV_ONLY;
               end
            endcase
         end
         DIV_START: begin
            div_start_o = 1'b1;
            div_a_o     = a_reg;
            div_b_o     = b_reg;
            div_rnd_o   = rnd_reg;
            state_next  = DIV_WAIT;
         end
         DIV_WAIT: begin
            div_a_o   = a_reg;
            div_b_o   = b_reg;
            div_rnd_o = rnd_reg;
            if (div_done_i) begin
               rsp_load   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         op_reg         <= OP_ADD;
         a_reg          <= '0;
         b_reg          <= '0;
         c_reg          <= '0;
         rnd_reg        <= RNE;
         tag_reg        <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= '0;
         rsp_flags_reg  <= '0;
         rsp_tag_reg    <= '0;
      end else begin
         if (accept) begin
            op_reg  <= req_op_i;
            a_reg   <= req_a_i;
            b_reg   <= req_b_i;
            c_reg   <= req_c_i;
            rnd_reg <= req_rnd_i;
            tag_reg <= req_tag_i;
         end
         if (rsp_load) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= rsp_result_next;
            rsp_flags_reg  <= rsp_flags_next;
            rsp_tag_reg    <= tag_reg;
         end else if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

   assign rsp_valid_o  = rsp_valid_reg;
   assign rsp_result_o = rsp_result_reg;
   assign rsp_flags_o  = rsp_flags_reg;
   assign rsp_tag_o    = rsp_tag_reg;

endmodule

// File: tb/tb_fp_op_sched.sv
// Directed and randomized bench for fp_op_sched; stub FMA/divider models plus an op-level reference.
module tb_fp_op_sched;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   fp_op_e      req_op = OP_ADD;
   logic [31:0] req_a = '0, req_b = '0, req_c = '0;
   roundmode_e  req_rnd = RNE;
   logic [3:0]  req_tag = '0;
   logic [31:0] fma_a, fma_b, fma_c, fma_result;
   logic        fma_sub;
   roundmode_e  fma_rnd;
   status_t     fma_flags;
   logic        div_start, div_done = 1'b0;
   logic [31:0] div_a, div_b, div_result;
   roundmode_e  div_rnd;
   status_t     div_flags;
   logic        rsp_valid, rsp_ready = 1'b1;
   logic [31:0] rsp_result;
   status_t     rsp_flags;
   logic [3:0]  rsp_tag;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fp_op_sched #(.FP_FORMAT(FP32), .TAG_WIDTH(4)) dut (
      .clk_i(clk), .reset_i(reset_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_rnd_i(req_rnd), .req_tag_i(req_tag),
      .fma_a_o(fma_a), .fma_b_o(fma_b), .fma_c_o(fma_c), .fma_sub_o(fma_sub), .fma_rnd_o(fma_rnd),
      .fma_result_i(fma_result), .fma_flags_i(fma_flags),
      .div_start_o(div_start), .div_a_o(div_a), .div_b_o(div_b), .div_rnd_o(div_rnd),
      .div_done_i(div_done), .div_result_i(div_result), .div_flags_i(div_flags),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
      .rsp_flags_o(rsp_flags), .rsp_tag_o(rsp_tag)
   );

   // Stub datapaths: exact answers for the directed cases, an input-sensitive hash otherwise.
   function automatic logic [31:0] fma_model(input logic [31:0] pa, pb, pc, input logic sub, input logic [2:0] rnd);
      if (pa == 32'h3F80_0000 && pb == 32'h3F80_0000 && pc == 32'h4000_0000 && !sub) return 32'h4040_0000;
      if (pa == 32'h0 && pc == 32'h0) return 32'h0;
      return pa ^ {pb[15:0], pb[31:16]} ^ (pc + 32'h0123_4567) ^ (sub ? 32'h5A5A_0000 : 32'h0) ^ {29'd0, rnd};
   endfunction

   function automatic logic [4:0] fma_flag_model(input logic [31:0] pa, pb, pc, input logic sub, input logic [2:0] rnd);
      if (pa == 32'h3F80_0000 && pb == 32'h3F80_0000 && pc == 32'h4000_0000 && !sub) return 5'd0;
      if (pa == 32'h0 && pc == 32'h0) return 5'd0;
      return pa[4:0] ^ pb[9:5] ^ pc[14:10] ^ {sub, 1'b0, rnd};
   endfunction

   function automatic logic [31:0] div_model(input logic [31:0] da, db, input logic [2:0] rnd);
      if (da == 32'h4040_0000 && db == 32'h3F80_0000) return 32'h4040_0000;
      return da ^ {db[7:0], db[31:8]} ^ 32'hC3C3_0000 ^ {29'd0, rnd};
   endfunction

   function automatic logic [4:0] div_flag_model(input logic [31:0] da, db, input logic [2:0] rnd);
      if (da == 32'h4040_0000 && db == 32'h3F80_0000) return 5'd0;
      return da[4:0] ^ db[12:8] ^ {2'b00, rnd};
   endfunction

   assign fma_result = fma_model(fma_a, fma_b, fma_c, fma_sub, fma_rnd);
   assign fma_flags  = status_t'(fma_flag_model(fma_a, fma_b, fma_c, fma_sub, fma_rnd));
   assign div_result = div_model(div_a, div_b, div_rnd);
   assign div_flags  = status_t'(div_flag_model(div_a, div_b, div_rnd));

   // Reference: what the FMA port bundle {a,b,c,sub,rnd} must be for each op code.
   function automatic logic [99:0] exp_fma_ports(input int op, input logic [31:0] a, b, c, input logic [2:0] rnd);
      case (op)
         0:       return {a, 32'h3F80_0000, b, 1'b0, rnd};
         1:       return {a, 32'h3F80_0000, b, 1'b1, rnd};
         2:       return {a, b, 32'h0, (rnd != 3'd2), rnd};
         3:       return {a, b, c, 1'b0, rnd};
         default: return 100'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic do_op(input int op, input logic [31:0] a, b, c, input logic [2:0] rnd,
                        input logic [3:0] tag, input int div_lat, input int stall, input bit noise);
      logic [99:0] ep;
      logic [31:0] er;
      logic [4:0]  ef;
      int          starts;
      bit          ok;
      rsp_ready = 1'b1;
      #1;
      check("req_ready_before_issue", req_ready, 1);
      req_valid = 1'b1;
      req_op    = fp_op_e'(op[2:0]);
      req_a     = a;
      req_b     = b;
      req_c     = c;
      req_rnd   = roundmode_e'(rnd);
      req_tag   = tag;
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      req_c     = $urandom;
      req_tag   = 4'($urandom);
      rsp_ready = (stall == 0);
      check("rsp_valid_latency", rsp_valid, 0);
      if (op == 4) begin
         starts = div_start ? 1 : 0;
         ok = ({div_a, div_b, 3'(div_rnd)} === {a, b, rnd});
         for (int k = 0; k < div_lat; k++) begin
            @(negedge clk);
            if (div_start) starts++;
            if ({div_a, div_b, 3'(div_rnd)} !== {a, b, rnd} || req_ready !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
            if (k == div_lat - 1) div_done = 1'b1;
         end
         check("div_start_pulses", starts, 1);
         check("div_operands_stable_busy", ok, 1);
         @(negedge clk);
         div_done = 1'b0;
         er = div_model(a, b, rnd);
         ef = div_flag_model(a, b, rnd);
      end else begin
         ep = exp_fma_ports(op, a, b, c, rnd);
         check("fma_ports", {fma_a, fma_b, fma_c, fma_sub, 3'(fma_rnd)}, ep);
         check("div_idle_zero", {div_start, div_a, div_b}, 0);
         if (noise) div_done = 1'b1;
         @(negedge clk);
         div_done = 1'b0;
         if (op < 4) begin
            er = fma_model(ep[99:68], ep[67:36], ep[35:4], ep[3], ep[2:0]);
            ef = fma_flag_model(ep[99:68], ep[67:36], ep[35:4], ep[3], ep[2:0]);
         end else begin
            er = 32'h7FC0_0000;
            ef = 5'b10000;
         end
      end
      check("rsp_valid", rsp_valid, 1);
      check("rsp_fields", {rsp_result, 5'(rsp_flags), rsp_tag}, {er, ef, tag});
      $display("txn op=%0d a=%h b=%h c=%h rnd=%0d tag=%h -> result=%h flags=%b", op, a, b, c, rnd, tag, rsp_result, rsp_flags);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("rsp_hold", {rsp_valid, rsp_result, 5'(rsp_flags), rsp_tag, req_ready}, {1'b1, er, ef, tag, 1'b0});
      end
   endtask

   initial begin
      bit got;
      // Reset state
      @(negedge clk);
      check("reset_outputs", {req_ready, rsp_valid, rsp_result, 5'(rsp_flags), rsp_tag, div_start},
            {1'b0, 1'b0, 32'h0, 5'h0, 4'h0, 1'b0});
      check("reset_fma_ports", {fma_a, fma_b, fma_c, fma_sub, div_a, div_b}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1);

      // ADD, MUL in both rounding directions, DIV with a slow divider
      do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd0, 4'h1, 0, 0, 0);
      do_op(2, 32'h0000_0000, 32'h3F80_0000, 32'hDEAD_BEEF, 3'd2, 4'h2, 0, 0, 0);
      do_op(2, 32'h0000_0000, 32'h3F80_0000, 32'h1234_5678, 3'd0, 4'h3, 0, 0, 0);
      do_op(4, 32'h4040_0000, 32'h3F80_0000, 32'h0, 3'd0, 4'h4, 27, 0, 0);

      // Response back-pressure, then an illegal op accepted as rsp_ready rises
      do_op(3, 32'h4120_0000, 32'h4000_0000, 32'h3F00_0000, 3'd1, 4'h6, 0, 3, 0);
      do_op(6, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'd0, 4'h5, 0, 0, 0);

      // Reset in DIV_WAIT abandons the divide; a stray done must not produce a response
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = OP_DIV;
      req_a     = 32'h4080_0000;
      req_b     = 32'h4000_0000;
      req_tag   = 4'h9;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_reset_outputs", {req_ready, rsp_valid, div_start, div_a, div_b}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", req_ready, 1);
      div_done = 1'b1;
      @(negedge clk);
      div_done = 1'b0;
      got = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      check("no_rsp_after_stray_done", got, 0);
      do_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 3'd0, 4'hA, 0, 0, 0);

      // Randomized mix including illegal codes, stalls and done noise
      for (int i = 0; i < 24; i++) begin
         do_op(int'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 3'($urandom_range(0, 4)),
               4'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'($urandom));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
